irq_exc_unit: RTL and testbench

IRQ_EXC_UNIT -- requirements
Module: irq_exc_unit

---
 rtl/exc_pkg.sv | 16 +
 rtl/prio_enc.sv | 20 ++
 rtl/irq_exc_unit.sv | 110 +++++++++++
 tb/tb_irq_exc_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared types and cause codes for the interrupt/exception unit.
package exc_pkg;

  // Controller states: normal execution, exception requested, handler running.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    EXC_REQ = 2'd1,
    HANDLER = 2'd2
  } exc_state_e;

  // EStatus cause codes; external channel i reports ES_IRQ_BASE + i.
  localparam int unsigned ES_NONE     = 0;
  localparam int unsigned ES_BADOP    = 1;
  localparam int unsigned ES_IRQ_BASE = 2;

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder with a valid flag.
module prio_enc #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/irq_exc_unit.sv
// Interrupt/exception controller: pends level IRQs, picks a cause, handshakes
// with the datapath and tracks handler entry/exit.
module irq_exc_unit
  import exc_pkg::*;
#(
  parameter int unsigned NUM_IRQ   = 4,
  parameter int unsigned ESTATUS_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_IRQ-1:0]   irq,
  input  logic [NUM_IRQ-1:0]   irq_mask,
  input  logic                 bad_op,
  input  logic                 ERet,
  input  logic                 ExcAck,
  output logic                 Exc,
  output logic [NUM_IRQ-1:0]   ExtIAck,
  output logic [ESTATUS_W-1:0] EStatus,
  output logic                 in_handler,
  output logic                 double_fault
);

  localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  exc_state_e           r_state, w_state_d;
  logic [NUM_IRQ-1:0]   r_pending, w_pending_d;
  logic [NUM_IRQ-1:0]   r_ack, w_ack_d;
  logic [ESTATUS_W-1:0] r_estatus, w_estatus_d;
  logic                 r_df, w_df_d;
  logic [NUM_IRQ-1:0]   w_eligible;
  logic                 w_sel_valid;
  logic [IDX_W-1:0]     w_sel_idx;

  // A request arriving this cycle is eligible immediately, giving 1-cycle latency to Exc.
  assign w_eligible = (r_pending | irq) & ~irq_mask;

  prio_enc #(
    .N     (NUM_IRQ),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .i_req   (w_eligible),
    .o_valid (w_sel_valid),
    .o_idx   (w_sel_idx)
  );

  // Next-state, cause capture, acknowledge pulse and double-fault logic.
  always_comb begin
    w_state_d   = r_state;
    w_estatus_d = r_estatus;
    w_df_d      = r_df;
    w_ack_d     = '0;
    unique case (r_state)
      RUN: begin
        if (bad_op) begin
          w_state_d   = EXC_REQ;
          w_estatus_d = ESTATUS_W'(ES_BADOP);
        end else if (w_sel_valid) begin
          w_state_d   = EXC_REQ;
          w_estatus_d = ESTATUS_W'(ES_IRQ_BASE) + ESTATUS_W'(w_sel_idx);
        end
      end
      EXC_REQ: begin
        if (ExcAck) begin
          w_state_d = HANDLER;
          for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (r_estatus == ESTATUS_W'(ES_IRQ_BASE + i)) w_ack_d[i] = 1'b1;
          end
        end
      end
      HANDLER: begin
        if (bad_op) w_df_d = 1'b1;
        if (ERet) begin
          w_state_d   = RUN;
          w_estatus_d = ESTATUS_W'(ES_NONE);
        end
      end
      default: begin
        w_state_d   = RUN;
        w_estatus_d = ESTATUS_W'(ES_NONE);
      end
    endcase
  end

  // New requests win over the acknowledge clear on the same edge.
  assign w_pending_d = (r_pending & ~w_ack_d) | irq;

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= RUN;
      r_pending <= '0;
      r_ack     <= '0;
      r_estatus <= '0;
      r_df      <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_pending <= w_pending_d;
      r_ack     <= w_ack_d;
      r_estatus <= w_estatus_d;
      r_df      <= w_df_d;
    end
  end

  assign Exc          = (r_state == EXC_REQ);
  assign in_handler   = (r_state == HANDLER);
  assign ExtIAck      = r_ack;
  assign EStatus      = r_estatus;
  assign double_fault = r_df;

endmodule

// File: tb/tb_irq_exc_unit.sv
// Directed and randomized checks of irq_exc_unit against a cycle-level model.
module tb_irq_exc_unit;

  localparam int N  = 4;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  irq, irq_mask;
  logic          bad_op, ERet, ExcAck;
  logic          Exc, in_handler, double_fault;
  logic [N-1:0]  ExtIAck;
  logic [EW-1:0] EStatus;

  int n_vec = 0;
  int n_bad = 0;

  // Model: mode 0 = running, 1 = exception requested, 2 = in handler.
  int         m_mode;
  bit [N-1:0] m_pend;
  int         m_cause;
  int         m_ack;
  bit         m_df;

  irq_exc_unit #(
    .NUM_IRQ   (N),
    .ESTATUS_W (EW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .irq          (irq),
    .irq_mask     (irq_mask),
    .bad_op       (bad_op),
    .ERet         (ERet),
    .ExcAck       (ExcAck),
    .Exc          (Exc),
    .ExtIAck      (ExtIAck),
    .EStatus      (EStatus),
    .in_handler   (in_handler),
    .double_fault (double_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_pend  = '0;
    m_cause = 0;
    m_ack   = -1;
    m_df    = 1'b0;
  endtask

  task automatic check_all(input string where);
    logic [N-1:0] ea;
    ea = '0;
    if (m_ack >= 0) ea[m_ack] = 1'b1;
    chk({where, ":Exc"},          32'(Exc),          32'(m_mode == 1));
    chk({where, ":in_handler"},   32'(in_handler),   32'(m_mode == 2));
    chk({where, ":EStatus"},      32'(EStatus),      32'(m_cause));
    chk({where, ":ExtIAck"},      32'(ExtIAck),      32'(ea));
    chk({where, ":double_fault"}, 32'(double_fault), 32'(m_df));
  endtask

  // One clock: predict from current inputs, advance, then compare.
  task automatic cycle(input string where);
    int         nm    = m_mode;
    int         nc    = m_cause;
    int         na    = -1;
    bit         ndf   = m_df;
    bit [N-1:0] np    = m_pend | irq;
    bit         found = 1'b0;
    if (m_mode == 0) begin
      if (bad_op) begin
        nm = 1;
        nc = 1;
      end else begin
        for (int j = 0; j < N; j++) begin
          if (!found && np[j] && !irq_mask[j]) begin
            found = 1'b1;
            nm    = 1;
            nc    = 2 + j;
          end
        end
      end
    end else if (m_mode == 1) begin
      if (ExcAck) begin
        nm = 2;
        if (m_cause >= 2) begin
          na     = m_cause - 2;
          np[na] = irq[na];
        end
      end
    end else begin
      if (bad_op) ndf = 1'b1;
      if (ERet) begin
        nm = 0;
        nc = 0;
      end
    end
    @(posedge clk);
    #1;
    m_mode  = nm;
    m_cause = nc;
    m_ack   = na;
    m_df    = ndf;
    m_pend  = np;
    check_all(where);
  endtask

  task automatic idle_inputs();
    irq    = '0;
    bad_op = 1'b0;
    ERet   = 1'b0;
    ExcAck = 1'b0;
  endtask

  // Assert reset between edges; outputs must clear before any clock.
  task automatic async_reset(input string where);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all(where);
    idle_inputs();
    irq_mask = '0;
    @(posedge clk);
    #1;
    check_all({where, "_hold"});
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    irq_mask = '0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;

    // bad_op in RUN, ack two cycles later
    bad_op = 1'b1; cycle("badop_req"); bad_op = 1'b0;
    chk("badop_EStatus", 32'(EStatus), 32'd1);
    cycle("badop_hold");
    chk("badop_Exc2", 32'(Exc), 32'd1);
    ExcAck = 1'b1; cycle("badop_ack"); ExcAck = 1'b0;
    chk("badop_in_handler", 32'(in_handler), 32'd1);
    chk("badop_noack", 32'(ExtIAck), 32'd0);
    ERet = 1'b1; cycle("badop_eret"); ERet = 1'b0;

    // Two channels, lower wins, then back-to-back service
    irq = 4'b1010; cycle("irq13_req"); irq = '0;
    chk("irq13_EStatus", 32'(EStatus), 32'd3);
    ExcAck = 1'b1; cycle("irq13_ack"); ExcAck = 1'b0;
    chk("irq13_ExtIAck", 32'(ExtIAck), 32'b0010);
    cycle("irq13_ackgone");
    ERet = 1'b1; cycle("irq13_eret"); ERet = 1'b0;
    cycle("irq3_req");
    chk("irq3_EStatus", 32'(EStatus), 32'd5);
    ExcAck = 1'b1; cycle("irq3_ack"); ExcAck = 1'b0;
    ERet = 1'b1; cycle("irq3_eret"); ERet = 1'b0;

    // Masked channel pends, then fires once unmasked
    irq_mask = 4'b0001;
    irq = 4'b0001; cycle("mask_pulse"); irq = '0;
    cycle("mask_wait1");
    cycle("mask_wait2");
    chk("mask_noExc", 32'(Exc), 32'd0);
    irq_mask = '0; cycle("unmask");
    chk("unmask_EStatus", 32'(EStatus), 32'd2);
    ExcAck = 1'b1; cycle("unmask_ack"); ExcAck = 1'b0;
    ERet = 1'b1; cycle("unmask_eret"); ERet = 1'b0;

    // bad_op beats irq[2]; irq[2] serviced afterwards
    bad_op = 1'b1; irq = 4'b0100; cycle("prio_req"); bad_op = 1'b0; irq = '0;
    chk("prio_EStatus", 32'(EStatus), 32'd1);
    ExcAck = 1'b1; cycle("prio_ack"); ExcAck = 1'b0;
    ERet = 1'b1; cycle("prio_eret"); ERet = 1'b0;
    cycle("prio_irq2");
    chk("prio_irq2_EStatus", 32'(EStatus), 32'd4);
    ExcAck = 1'b1; cycle("prio_irq2_ack"); ExcAck = 1'b0;
    ERet = 1'b1; cycle("prio_irq2_eret"); ERet = 1'b0;

    // Double fault is sticky, handler persists until ERet
    bad_op = 1'b1; cycle("df_req"); bad_op = 1'b0;
    ExcAck = 1'b1; cycle("df_ack"); ExcAck = 1'b0;
    bad_op = 1'b1; cycle("df_set"); bad_op = 1'b0;
    chk("df_flag", 32'(double_fault), 32'd1);
    cycle("df_stay");
    chk("df_in_handler", 32'(in_handler), 32'd1);
    ERet = 1'b1; cycle("df_eret"); ERet = 1'b0;
    chk("df_sticky", 32'(double_fault), 32'd1);

    // Reset in the middle of an exception request
    bad_op = 1'b1; cycle("rst_req"); bad_op = 1'b0;
    async_reset("rst_mid_req");

    // Randomized traffic with occasional asynchronous reset
    for (int k = 0; k < 600; k++) begin
      irq      = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      irq_mask = ($urandom_range(0, 7) == 0) ? N'($urandom) : irq_mask;
      bad_op   = ($urandom_range(0, 9) == 0);
      ExcAck   = ($urandom_range(0, 2) == 0);
      ERet     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
      else cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
